// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory responder: RV32I funct3 access codes,
// MMIO register offsets and the fault counter width.
package dmem_pkg;

  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;
  localparam logic [2:0] FN3_SB  = 3'b000;
  localparam logic [2:0] FN3_SH  = 3'b001;
  localparam logic [2:0] FN3_SW  = 3'b010;

  localparam logic [31:0] MMIO_OFF_CYCLE   = 32'd0;
  localparam logic [31:0] MMIO_OFF_SCRATCH = 32'd4;
  localparam logic [31:0] MMIO_OFF_FAULTS  = 32'd8;

  localparam int unsigned FAULT_CNT_W = 8;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane logic for the data memory: load extract/extend, store lane
// replication with byte enables, and size/alignment/encoding error detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  fn3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  byte_en,
  output logic        align_err
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = rdata >> {addr_lo, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data  = 32'h0;
    store_data = wdata;
    byte_en    = 4'b0000;
    align_err  = 1'b0;
    case (fn3)
      FN3_LB: begin
        load_data  = {{24{byte_sel[7]}}, byte_sel};
        store_data = {4{wdata[7:0]}};
        byte_en    = 4'b0001 << addr_lo;
      end
      FN3_LH: begin
        align_err  = addr_lo[0];
        load_data  = {{16{half_sel[15]}}, half_sel};
        store_data = {2{wdata[15:0]}};
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      FN3_LW: begin
        align_err  = (addr_lo != 2'b00);
        load_data  = rdata;
        byte_en    = 4'b1111;
      end
      // unsigned variants exist only for loads
      FN3_LBU: begin
        align_err  = is_store;
        load_data  = {24'h0, byte_sel};
      end
      FN3_LHU: begin
        align_err  = is_store | addr_lo[0];
        load_data  = {16'h0, half_sel};
      end
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-cycle RV32I data memory with fault tracking; defining DMEM_MMIO_EN
// adds a word-only MMIO window (cycle counter, scratch, fault count).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             fn3,
  input  logic [31:0]            address,
  input  logic [31:0]            wdata,
  output logic [31:0]            mem_out,
  output logic                   misalign_err,
  output logic [FAULT_CNT_W-1:0] fault_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   rdata_word;
  logic [31:0]   load_data;
  logic [31:0]   store_data;
  logic [3:0]    byte_en;
  logic          align_err;
  logic          in_array;
  logic          in_mmio;
  logic          mmio_size_err;
  logic [31:0]   mmio_rdata;
  logic          fc_clear;
  logic          active;
  logic          fault;
  logic          array_we;

  assign word_idx   = address[AW+1:2];
  assign rdata_word = mem[word_idx];
  assign in_array   = (address[31:AW+2] == '0);

  dmem_lane_align u_lane (
    .fn3        (fn3),
    .is_store   (mem_write),
    .addr_lo    (address[1:0]),
    .rdata      (rdata_word),
    .wdata      (wdata),
    .load_data  (load_data),
    .store_data (store_data),
    .byte_en    (byte_en),
    .align_err  (align_err)
  );

  assign active = mem_read | mem_write;
  assign fault  = active & ((mem_read & mem_write) | align_err | mmio_size_err |
                            ~(in_array | in_mmio));

  assign mem_out  = (mem_read && !fault) ? (in_mmio ? mmio_rdata : load_data) : 32'h0;
  assign array_we = mem_write & ~fault & ~reset & in_array;

  // array is deliberately not reset
  always_ff @(posedge clk) begin
    if (array_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] mmio_off;
  logic [31:0] cycle_cnt;
  logic [31:0] scratch;
  logic        mmio_we;

  assign mmio_off      = address - MMIO_BASE;
  assign in_mmio       = (address >= MMIO_BASE) && (mmio_off < 32'd12);
  assign mmio_size_err = in_mmio && (fn3 != FN3_LW);
  assign mmio_we       = mem_write & ~fault & in_mmio;
  assign fc_clear      = mmio_we && (mmio_off == MMIO_OFF_FAULTS);

  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_off)
      MMIO_OFF_CYCLE:   mmio_rdata = cycle_cnt;
      MMIO_OFF_SCRATCH: mmio_rdata = scratch;
      MMIO_OFF_FAULTS:  mmio_rdata = {{(32-FAULT_CNT_W){1'b0}}, fault_count};
      default:          mmio_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= 32'h0;
      scratch   <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (mmio_we && (mmio_off == MMIO_OFF_SCRATCH)) scratch <= wdata;
    end
  end
`else
  logic unused_mmio_base;

  assign unused_mmio_base = ^MMIO_BASE;
  assign in_mmio          = 1'b0;
  assign mmio_size_err    = 1'b0;
  assign mmio_rdata       = 32'h0;
  assign fc_clear         = 1'b0;
`endif

  // a clearing write wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
      fault_count  <= '0;
    end else begin
      misalign_err <= fault;
      if (fc_clear)
        fault_count <= '0;
      else if (fault && (fault_count != '1))
        fault_count <= fault_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder; MMIO cases follow DMEM_MMIO_EN.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  fn3;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] mem_out;
  logic        misalign_err;
  logic [7:0]  fault_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_out;

  data_mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .fn3          (fn3),
    .address      (address),
    .wdata        (wdata),
    .mem_out      (mem_out),
    .misalign_err (misalign_err),
    .fault_count  (fault_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one access: drive at negedge, sample mem_out mid-low-phase, commit at posedge
  task automatic cycle(input logic rd, input logic wr, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_read = rd; mem_write = wr; fn3 = f; address = a; wdata = d;
    #2 last_out = mem_out;
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, FN3_LW, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [2:0] f, input logic [31:0] a);
    cycle(1'b1, 1'b0, f, a, 32'h0);
  endtask

  task automatic store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, f, a, d);
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    fn3 = 3'b000; address = 32'h0; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fault_count", {24'h0, fault_count}, 32'h0);
    check("rst_misalign", {31'h0, misalign_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

`ifdef DMEM_MMIO_EN
    idle(4);
    load(FN3_LW, 32'h0000_1000);
    check("mmio_cycle_cnt", last_out, 32'd5);
    store(FN3_SW, 32'h0000_1000, 32'h1234_5678);
    check("mmio_cnt_wr_nofault", {24'h0, fault_count}, 32'h0);
    store(FN3_SW, 32'h0000_1004, 32'hA5A5_A5A5);
    load(FN3_LW, 32'h0000_1004);
    check("mmio_scratch", last_out, 32'hA5A5_A5A5);
    load(FN3_LH, 32'h0000_1004);
    check("mmio_half_out", last_out, 32'h0);
    check("mmio_half_fault", {24'h0, fault_count}, 32'h1);
    load(FN3_LW, 32'h0000_1008);
    check("mmio_read_faults", last_out, 32'h1);
    store(FN3_SW, 32'h0000_1008, 32'h0);
    check("mmio_clear_faults", {24'h0, fault_count}, 32'h0);
`endif

    store(FN3_SW, 32'h10, 32'hDEAD_BEEF);
    check("sw_no_err", {31'h0, misalign_err}, 32'h0);
    load(FN3_LW, 32'h10);
    check("lw_after_sw", last_out, 32'hDEAD_BEEF);
    load(FN3_LB, 32'h13);
    check("lb_13", last_out, 32'hFFFF_FFDE);
    load(FN3_LBU, 32'h13);
    check("lbu_13", last_out, 32'h0000_00DE);
    load(FN3_LH, 32'h12);
    check("lh_12", last_out, 32'hFFFF_DEAD);
    load(FN3_LHU, 32'h12);
    check("lhu_12", last_out, 32'h0000_DEAD);
    load(FN3_LB, 32'h10);
    check("lb_10", last_out, 32'hFFFF_FFEF);

    store(FN3_SB, 32'h11, 32'hFFFF_FF5A);
    load(FN3_LW, 32'h10);
    check("sb_11", last_out, 32'hDEAD_5AEF);
    store(FN3_SH, 32'h12, 32'hABCD_1234);
    load(FN3_LW, 32'h10);
    check("sh_12", last_out, 32'h1234_5AEF);
    cycle(1'b0, 1'b0, FN3_LW, 32'h10, 32'h0);
    check("no_read_out", last_out, 32'h0);

    store(FN3_SW, 32'h20, 32'hCAFE_F00D);
    load(FN3_LW, 32'h11);
    check("lw_mis_out", last_out, 32'h0);
    check("lw_mis_err", {31'h0, misalign_err}, 32'h1);
    check("lw_mis_cnt", {24'h0, fault_count}, 32'h1);
    idle(1);
    check("err_one_cycle", {31'h0, misalign_err}, 32'h0);
    store(FN3_SW, 32'h22, 32'h1111_1111);
    check("sw_mis_cnt", {24'h0, fault_count}, 32'h2);
    load(FN3_LW, 32'h20);
    check("sw_mis_nowrite", last_out, 32'hCAFE_F00D);

    cycle(1'b1, 1'b1, FN3_SW, 32'h10, 32'h0);
    check("rdwr_out", last_out, 32'h0);
    check("rdwr_cnt", {24'h0, fault_count}, 32'h3);
    load(FN3_LW, 32'h10);
    check("rdwr_nowrite", last_out, 32'h1234_5AEF);

    load(3'b011, 32'h10);
    check("fn3_011_out", last_out, 32'h0);
    store(FN3_LBU, 32'h10, 32'h0);
    check("store_lbu_cnt", {24'h0, fault_count}, 32'h5);
    store(3'b110, 32'h10, 32'h0);
    load(FN3_LW, 32'h10);
    check("bad_store_nowrite", last_out, 32'h1234_5AEF);
    check("bad_fn3_cnt", {24'h0, fault_count}, 32'h6);

    load(FN3_LW, 32'h400);
    check("oor_out", last_out, 32'h0);
`ifdef DMEM_MMIO_EN
    load(FN3_LW, 32'h0000_100C);
`else
    load(FN3_LW, 32'h0000_1000);
`endif
    check("mmio_oor_out", last_out, 32'h0);
    check("oor_cnt", {24'h0, fault_count}, 32'h8);

    for (int i = 0; i < 260; i++) begin
      load(FN3_LH, 32'h11);
      if (i == 1) check("b2b_err_held", {31'h0, misalign_err}, 32'h1);
    end
    check("sat_cnt", {24'h0, fault_count}, 32'hFF);
    check("sat_err", {31'h0, misalign_err}, 32'h1);

    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, 1'b1, FN3_SW, 32'h10, 32'h0BAD_F00D);
    check("rst_clears_cnt", {24'h0, fault_count}, 32'h0);
    check("rst_clears_err", {31'h0, misalign_err}, 32'h0);
    load(FN3_LW, 32'h10);
    check("load_in_reset", last_out, 32'h1234_5AEF);
    @(negedge clk);
    reset = 1'b0;
    load(FN3_LW, 32'h10);
    check("rst_store_dropped", last_out, 32'h1234_5AEF);
    load(FN3_LW, 32'h20);
    check("array_persists", last_out, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
